// File: rtl/leaf_fifo_pkg.sv
// Shared defaults and pointer type for the leaf stream FIFO.
// Optional high-water-mark logic is enabled with LEAF_FIFO_HWM_EN.
package leaf_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 8;

    // Pointer for the default depth: one extra MSB acts as the wrap flag.
    typedef logic [$clog2(DEFAULT_DEPTH):0] ptr_t;

endpackage

// File: rtl/leaf_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, combinational read, no reset.
module leaf_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/leaf_stream_fifo.sv
// First-word fall-through valid/ready FIFO placed upstream of each leaf stage.
// Define LEAF_FIFO_HWM_EN to add the hwm/hwm_clr high-water-mark ports.
module leaf_stream_fifo
    import leaf_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
`ifdef LEAF_FIFO_HWM_EN
    ,
    output logic [ADDR_W:0]   hwm,
    input  logic              hwm_clr
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            push;
    logic            pop;

    // Equal low bits with differing wrap flags means the writer is a full lap ahead.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level     = wr_ptr - rd_ptr;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    leaf_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (out_data)
    );

`ifdef LEAF_FIFO_HWM_EN
    logic [ADDR_W:0] hwm_q;
    logic [ADDR_W:0] hwm_d;

    // Clear wins over a coinciding new maximum; both load the current level.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr || (level > hwm_q)) begin
            hwm_d = level;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Scoreboard bench for leaf_stream_fifo: directed fill/drain/wrap/reset vectors.
// Build with LEAF_FIFO_HWM_EN defined to also exercise the high-water mark.
`timescale 1ns/1ps
module tb_leaf_stream_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] level;
    logic       full;
    logic       empty;
`ifdef LEAF_FIFO_HWM_EN
    logic [3:0] hwm;
    logic       hwm_clr;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    leaf_stream_fifo #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
`ifdef LEAF_FIFO_HWM_EN
        ,
        .hwm       (hwm),
        .hwm_clr   (hwm_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: records accepted words and compares every consumed head.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got 0x%0h expected none at %0t", out_data, $time);
                end else begin
                    check("sb_data", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    task automatic cycle(input logic pv, input logic pr, input logic [7:0] d);
        in_valid  = pv;
        in_data   = d;
        out_ready = pr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    int lvl;
    int dval;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef LEAF_FIFO_HWM_EN
        hwm_clr   = 1'b0;
`endif
        #2;
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 fill
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 8'(i + 1));
            check("t1_level", int'(level), i + 1);
        end
        check("t1_full", int'(full), 1);
        check("t1_in_ready", int'(in_ready), 0);
        cycle(1'b1, 1'b0, 8'h09);
        check("t1_reject_level", int'(level), 8);
        check("t1_reject_head", int'(out_data), 8'h01);

        // T2 drain
        for (int i = 0; i < 8; i++) begin
            check("t2_head", int'(out_data), i + 1);
            cycle(1'b0, 1'b1, 8'h00);
        end
        check("t2_empty", int'(empty), 1);
        check("t2_level", int'(level), 0);

        // T3 interleaved push/pop across the pointer wrap, level held in 1..3
        cycle(1'b1, 1'b0, 8'h10);
        lvl  = 1;
        dval = 8'h11;
        for (int k = 0; k < 20; k++) begin
            if ((k % 4) < 2) begin
                cycle(1'b1, 1'b0, 8'(dval));
                dval++;
                lvl++;
            end else begin
                cycle(1'b0, 1'b1, 8'h00);
                lvl--;
            end
            check("t3_level", int'(level), lvl);
            check("t3_range", int'(level >= 4'd1 && level <= 4'd3), 1);
        end
        cycle(1'b0, 1'b1, 8'h00);
        check("t3_empty", int'(empty), 1);

        // T4 simultaneous push and pop at level 4
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h41 + i));
        end
        check("t4_level_pre", int'(level), 4);
        cycle(1'b1, 1'b1, 8'h45);
        check("t4_level_post", int'(level), 4);
        check("t4_head", int'(out_data), 8'h42);
        cycle(1'b1, 1'b0, 8'h46);
        check("t4_level5", int'(level), 5);

        // T5 asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_level", int'(level), 0);
        check("t5_in_ready", int'(in_ready), 1);
        check("t5_empty", int'(empty), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check("t5_no_bypass", int'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_latency_valid", int'(out_valid), 1);
        check("t5_first_head", int'(out_data), 8'h77);
        check("t5_level1", int'(level), 1);
        cycle(1'b0, 1'b1, 8'h00);
        check("t5_drained", int'(empty), 1);

`ifdef LEAF_FIFO_HWM_EN
        // T6 high-water mark
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h60 + i));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
        end
        check("t6_level", int'(level), 2);
        check("t6_hwm", int'(hwm), 6);
        hwm_clr = 1'b1;
        @(posedge clk);
        #1;
        hwm_clr = 1'b0;
        check("t6_hwm_clr", int'(hwm), 2);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        check("t6_empty", int'(empty), 1);
`endif

        @(negedge clk);
        check("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
